// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the X-interface dispatcher: offload ID type and ID-table entry.
package cv32e40p_x_if_pkg;

    localparam int unsigned X_ID_WIDTH_DEFAULT = 3;

    typedef logic [X_ID_WIDTH_DEFAULT-1:0] x_id_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/cv32e40p_x_sb_cnt.sv
// Per-register pending-write counters: one increment and one decrement port per cycle.
module cv32e40p_x_sb_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_en,
    input  logic [4:0]  inc_addr,
    input  logic        dec_en,
    input  logic [4:0]  dec_addr,
    output logic [31:0] nz,
    output logic [31:0] sat
);

    for (genvar r = 0; r < 32; r++) begin : g_reg
        logic [CNT_W-1:0] cnt_q;
        logic             inc, dec;

        assign inc = inc_en & (inc_addr == 5'(r));
        assign dec = dec_en & (dec_addr == 5'(r));

        // Simultaneous inc and dec on the same register cancel out
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (inc & ~dec) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (dec & ~inc) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign nz[r]  = |cnt_q;
        assign sat[r] = &cnt_q;
    end

endmodule

// File: rtl/cv32e40p_x_disp_mo.sv
// Multi-outstanding X-interface dispatcher: offloads decoder-rejected instructions and
// tracks in-flight writebacks by ID with a counting per-register scoreboard.
module cv32e40p_x_disp_mo
    import cv32e40p_x_if_pkg::*;
#(
    parameter int unsigned X_NUM_RS        = 3,
    parameter int unsigned X_ID_WIDTH      = X_ID_WIDTH_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned SB_CNT_WIDTH    = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           x_illegal_insn_dec_i,
    input  logic                           x_writeback_i,
    input  logic [4:0]                     x_waddr_id_i,
    input  logic [X_NUM_RS-1:0][4:0]       x_rs_addr_i,
    input  logic [X_NUM_RS-1:0]            x_regs_used_i,
    input  logic [4:0]                     x_waddr_ex_i,
    input  logic                           x_we_ex_i,
    input  logic [4:0]                     x_waddr_wb_i,
    input  logic                           x_we_wb_i,
    input  logic                           x_ex_valid_i,
    input  logic                           x_branch_or_jump_i,
    input  logic                           x_load_stall_i,
    input  logic                           id_ready_i,
    output logic                           x_valid_o,
    input  logic                           x_ready_i,
    input  logic                           x_accept_i,
    output logic [X_ID_WIDTH-1:0]          x_id_o,
    output logic [X_NUM_RS-1:0]            x_rs_valid_o,
    output logic                           x_rd_clean_o,
    input  logic                           x_result_valid_i,
    input  logic [X_ID_WIDTH-1:0]          x_result_id_i,
    output logic [4:0]                     x_result_rd_o,
    output logic                           x_result_ready_o,
    output logic                           x_stall_o,
    output logic                           x_illegal_insn_o,
    output logic                           x_result_err_o
);

    localparam int unsigned N_ID  = 2 ** X_ID_WIDTH;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    sb_entry_t             tbl_q [N_ID];
    logic [X_ID_WIDTH-1:0] next_id_q;
    logic [OUT_W-1:0]      outst_q;
    logic                  issued_q;
    logic [31:0]           nz, sat_v;

    logic rd_nz, wb_rd, full, sat, hs, iss_wb, res_hit, dep_any, dep;

    assign rd_nz  = x_waddr_id_i != 5'd0;
    assign wb_rd  = x_writeback_i & rd_nz;
    assign full   = (outst_q == OUT_W'(MAX_OUTSTANDING)) | tbl_q[next_id_q].valid;
    assign sat    = sat_v[x_waddr_id_i] & wb_rd;

    assign x_valid_o = ~rst_i & x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~x_load_stall_i
                     & ~issued_q & ~full & ~sat;
    assign x_id_o    = next_id_q;
    assign hs        = x_valid_o & x_ready_i;
    assign iss_wb    = hs & x_accept_i & wb_rd;

    assign x_illegal_insn_o = hs & ~x_accept_i;
    assign x_result_rd_o    = tbl_q[x_result_id_i].rd;
    assign res_hit          = ~rst_i & x_result_valid_i & tbl_q[x_result_id_i].valid;
    assign x_result_err_o   = ~rst_i & x_result_valid_i & ~tbl_q[x_result_id_i].valid;
    assign x_result_ready_o = 1'b1;

    cv32e40p_x_sb_cnt #(.CNT_W(SB_CNT_WIDTH)) i_sb_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_en   (iss_wb),
        .inc_addr (x_waddr_id_i),
        .dec_en   (res_hit),
        .dec_addr (tbl_q[x_result_id_i].rd),
        .nz       (nz),
        .sat      (sat_v)
    );

    // EX/WB hazards on sources are masked once EX can forward its result
    always_comb begin
        x_rs_valid_o = '0;
        dep_any      = 1'b0;
        for (int i = 0; i < X_NUM_RS; i++) begin
            x_rs_valid_o[i] = (x_rs_addr_i[i] == 5'd0) |
                ~(nz[x_rs_addr_i[i]] |
                  ((x_rs_addr_i[i] == x_waddr_ex_i) & x_we_ex_i & ~x_ex_valid_i) |
                  ((x_rs_addr_i[i] == x_waddr_wb_i) & x_we_wb_i & ~x_ex_valid_i));
            dep_any = dep_any | (x_regs_used_i[i] & nz[x_rs_addr_i[i]]);
        end
    end

    assign x_rd_clean_o = ~rd_nz |
        ~(nz[x_waddr_id_i] |
          ((x_waddr_id_i == x_waddr_ex_i) & x_we_ex_i) |
          ((x_waddr_id_i == x_waddr_wb_i) & x_we_wb_i));

    assign dep       = ~x_illegal_insn_o & ~x_illegal_insn_dec_i & dep_any;
    assign x_stall_o = (x_valid_o & ~x_ready_i) | dep |
                       (x_illegal_insn_dec_i & ~issued_q & (full | sat));

    // A slot freed this cycle cannot be re-issued this cycle: full reads registered valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ID; i++) tbl_q[i] <= '0;
            next_id_q <= '0;
            outst_q   <= '0;
            issued_q  <= 1'b0;
        end else begin
            if (res_hit) tbl_q[x_result_id_i].valid <= 1'b0;
            if (iss_wb) tbl_q[next_id_q] <= '{valid: 1'b1, rd: x_waddr_id_i};
            if (hs & x_accept_i) next_id_q <= next_id_q + 1'b1;
            if (iss_wb & ~res_hit)      outst_q <= outst_q + 1'b1;
            else if (res_hit & ~iss_wb) outst_q <= outst_q - 1'b1;
            if (id_ready_i)  issued_q <= 1'b0;
            else if (hs)     issued_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_disp_mo.sv
// Directed bench: stimulus pushes expected output snapshots, a negedge monitor compares them.
module tb_cv32e40p_x_disp_mo;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec, wb, bj, ls, idr, rdy, acc, rv, we_ex, we_wb, ex_valid;
    logic [4:0]      rd, waddr_ex, waddr_wb;
    logic [2:0][4:0] rs;
    logic [2:0]      used;
    logic [2:0]      rid;

    logic            vld, stall, ill, err, clean, rrdy;
    logic [2:0]      id, rsv;
    logic [4:0]      rrd;

    cv32e40p_x_disp_mo #(.X_NUM_RS(3), .X_ID_WIDTH(3), .MAX_OUTSTANDING(4), .SB_CNT_WIDTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_illegal_insn_dec_i(dec), .x_writeback_i(wb), .x_waddr_id_i(rd),
        .x_rs_addr_i(rs), .x_regs_used_i(used),
        .x_waddr_ex_i(waddr_ex), .x_we_ex_i(we_ex), .x_waddr_wb_i(waddr_wb), .x_we_wb_i(we_wb),
        .x_ex_valid_i(ex_valid), .x_branch_or_jump_i(bj), .x_load_stall_i(ls),
        .id_ready_i(idr), .x_valid_o(vld), .x_ready_i(rdy), .x_accept_i(acc),
        .x_id_o(id), .x_rs_valid_o(rsv), .x_rd_clean_o(clean),
        .x_result_valid_i(rv), .x_result_id_i(rid), .x_result_rd_o(rrd),
        .x_result_ready_o(rrdy), .x_stall_o(stall), .x_illegal_insn_o(ill),
        .x_result_err_o(err)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] M_RDY = 17'h10000, M_VLD = 17'h08000, M_ID  = 17'h07000,
                            M_STL = 17'h00800, M_ILL = 17'h00400, M_ERR = 17'h00200,
                            M_CLN = 17'h00100, M_RSV = 17'h000E0, M_RRD = 17'h0001F;

    typedef struct {
        string       nm;
        logic [16:0] v;
        logic [16:0] m;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [16:0] ev(logic v_, logic [2:0] id_, logic stl, logic il, logic er,
                                       logic cl, logic [2:0] rs_, logic [4:0] rr);
        return {1'b1, v_, id_, stl, il, er, cl, rs_, rr};
    endfunction

    always @(negedge clk) begin : mon
        exp_t        e;
        logic [16:0] obs;
        if (q.size() > 0) begin
            e   = q.pop_front();
            obs = {rrdy, vld, id, stall, ill, err, clean, rsv, rrd};
            checks++;
            if ((obs & e.m) === (e.v & e.m)) passes++;
            else $display("FAIL %s: got %h want %h (mask %h)", e.nm, obs & e.m, e.v & e.m, e.m);
        end
    end

    task automatic step(input string nm, input logic [16:0] v, input logic [16:0] m);
        exp_t e;
        e.nm = nm; e.v = v; e.m = m;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        dec = 0; wb = 0; rd = 0; rs = '0; used = 0; bj = 0; ls = 0; idr = 1;
        rdy = 0; acc = 0; rv = 0; rid = 0; we_ex = 0; we_wb = 0; ex_valid = 0;
        waddr_ex = 0; waddr_wb = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); dec = 1; wb = 1; rd = r; rdy = 1; acc = 1;
    endtask

    localparam logic [16:0] M_ISS = M_VLD | M_ID | M_STL | M_ILL;

    initial begin
        idle(); rst = 1;
        @(posedge clk); #1;
        dec = 1; rv = 1; rid = 6;
        step("reset_outputs_low", ev(0,0,0,0,0,0,0,0), M_VLD | M_ILL | M_ERR);
        idle();
        step("reset_hold", ev(0,0,0,0,0,0,0,0), M_VLD);
        rst = 0; rd = 5;
        step("post_reset_idle", ev(0,0,0,0,0,1,3'b111,0), M_RDY | M_VLD | M_ID | M_STL | M_CLN | M_RSV);

        // single writeback to x5, dependent core instruction, result release
        dec = 1; ls = 1;
        step("load_stall_blocks", ev(0,0,0,0,0,0,0,0), M_VLD | M_STL);
        issue(5);
        step("issue_rd5_id0", ev(1,0,0,0,0,0,0,0), M_ISS);
        idle(); rd = 5; rs[0] = 5; used = 3'b001; rid = 0;
        step("dep_on_x5", ev(0,1,1,0,0,0,3'b110,5), M_ID | M_STL | M_CLN | M_RSV | M_RRD);
        rv = 1;
        step("dep_during_result", ev(0,0,1,0,0,0,0,0), M_STL | M_ERR);
        rv = 0;
        step("dep_released", ev(0,0,0,0,0,1,3'b111,0), M_STL | M_CLN | M_RSV);

        // fill to MAX_OUTSTANDING, freed slot is only usable the following cycle
        for (int k = 1; k <= 4; k++) begin
            issue(5'(k));
            step($sformatf("fill_id%0d", k), ev(1,3'(k),0,0,0,0,0,0), M_ISS);
        end
        issue(6);
        step("full_blocks", ev(0,0,1,0,0,0,0,0), M_VLD | M_STL);
        rv = 1; rid = 2;
        step("full_same_cycle_free", ev(0,0,1,0,0,0,0,0), M_VLD | M_STL | M_ERR);
        rv = 0;
        step("resume_id5", ev(1,5,0,0,0,0,0,0), M_ISS);
        begin
            logic [2:0] ids [4] = '{3'd1, 3'd3, 3'd4, 3'd5};
            logic [4:0] rds [4] = '{5'd1, 5'd3, 5'd4, 5'd6};
            for (int k = 0; k < 4; k++) begin
                idle(); rv = 1; rid = ids[k];
                step($sformatf("drain_id%0d", ids[k]), ev(0,0,0,0,0,0,0,rds[k]), M_ERR | M_RRD);
            end
        end

        // counter saturation on x7, with an issue and release colliding on x7
        issue(7); step("sat_iss_id6", ev(1,6,0,0,0,0,0,0), M_ISS);
        issue(7); step("sat_iss_id7", ev(1,7,0,0,0,0,0,0), M_ISS);
        issue(7); rv = 1; rid = 6;
        step("sat_iss_id0_with_result", ev(1,0,0,0,0,0,0,0), M_ISS | M_ERR);
        issue(7); step("sat_iss_id1", ev(1,1,0,0,0,0,0,0), M_ISS);
        issue(7); step("sat_blocks", ev(0,2,1,0,0,0,0,0), M_VLD | M_ID | M_STL | M_CLN);
        begin
            logic [2:0] ids [3] = '{3'd7, 3'd0, 3'd1};
            for (int k = 0; k < 3; k++) begin
                idle(); rv = 1; rid = ids[k];
                step($sformatf("sat_drain_id%0d", ids[k]), ev(0,0,0,0,0,0,0,7), M_ERR | M_RRD);
            end
        end
        idle(); rd = 7;
        step("x7_clean_again", ev(0,0,0,0,0,1,0,0), M_CLN);

        // coprocessor rejection
        issue(9); acc = 0;
        step("reject_pulse", ev(1,2,0,1,0,0,0,0), M_ISS);
        idle(); rd = 9;
        step("reject_no_sb", ev(0,0,0,0,0,1,0,0), M_ILL | M_CLN);

        // issued_q holds off re-issue until ID advances
        issue(0); wb = 0; idr = 0;
        step("hold_first", ev(1,0,0,0,0,0,0,0), M_VLD | M_ILL);
        step("hold_issued", ev(0,0,0,0,0,0,0,0), M_VLD | M_STL);
        idr = 1;
        step("hold_clear_cycle", ev(0,0,0,0,0,0,0,0), M_VLD);

        // unknown result ID
        idle(); rv = 1; rid = 6;
        step("err_unknown_id", ev(0,0,0,0,1,0,0,0), M_ERR);
        rv = 0;
        step("err_one_cycle", ev(0,0,0,0,0,0,0,0), M_ERR);

        // EX/WB forwarding and x0
        idle(); rs[0] = 3; used = 3'b001; waddr_ex = 3; we_ex = 1; rd = 3;
        step("ex_hazard", ev(0,0,0,0,0,0,3'b110,0), M_RSV | M_CLN | M_STL);
        ex_valid = 1;
        step("ex_forward", ev(0,0,0,0,0,0,3'b111,0), M_RSV | M_CLN);
        ex_valid = 0; rs[0] = 0; rs[1] = 4; waddr_ex = 0; waddr_wb = 4; we_wb = 1; rd = 0;
        step("wb_hazard_x0", ev(0,0,0,0,0,1,3'b101,0), M_RSV | M_CLN);

        // reset with three outstanding
        issue(10); step("pre_rst_10", ev(1,0,0,0,0,0,0,0), M_VLD);
        issue(11); step("pre_rst_11", ev(1,0,0,0,0,0,0,0), M_VLD);
        issue(12); step("pre_rst_12", ev(1,0,0,0,0,0,0,0), M_VLD);
        idle(); rd = 10; rs[0] = 11; used = 3'b001;
        step("pre_rst_busy", ev(0,0,1,0,0,0,3'b110,0), M_STL | M_CLN | M_RSV);
        rst = 1; dec = 1;
        step("rst_blocks", ev(0,0,0,0,0,0,0,0), M_VLD | M_ILL);
        rst = 0; dec = 0;
        step("post_rst_clean", ev(0,0,0,0,0,1,3'b111,0), M_ID | M_STL | M_CLN | M_RSV);
        issue(10);
        step("post_rst_issue", ev(1,0,0,0,0,0,0,0), M_ISS);
        idle();

        @(negedge clk); #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
